cla_pipe_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder for the floating-point datapath (F_Mul mantissa/exponent sums and wide partial-product accumulation). WIDTH-bit operands are split into STAGES equal slices. Each pipeline stage adds one slice with 4-bit lookahead groups and registers the slice carry into the next stage. Accepts one operation per cycle under a valid/ready handshake and returns sum, carry-out and signed overflow after STAGES cycles.

---
 rtl/cla_pipe_adder.sv | 201 ++++++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder
//
// Pipelined carry-lookahead adder. The WIDTH-bit operands are cut into STAGES
// equal slices of SW = WIDTH/STAGES bits. Stage k adds slice k using 4-bit
// lookahead groups, which ripple from group to group inside the slice. It then
// registers three things for stage k+1: the finished low sum bits, the carry
// out of the slice, and the operands (the skew buffer that still holds the
// upper slices). The last stage register drives the outputs.
//
// WIDTH must be a multiple of 4*STAGES. STAGES may be 1..8.
//
// Optional feature, enabled by the macro CLA_PIPE_SUB_EN:
//   The input port `sub` exists. With sub=1 the block computes op1 - op2.
//   Stage 0 uses ~op2 and forces the bit-0 carry to 1, and cin is ignored.
//   In this mode cout=1 means no borrow. The inverted operand and the forced
//   carry are registered in stage 0, so the selection travels with the op.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active high
//   in_valid   in   operation present on op1/op2/cin(/sub)
//   in_ready   out  operation accepted this cycle if in_valid
//   op1, op2   in   WIDTH-bit operands
//   cin        in   carry into bit 0
//   sub        in   subtract select (CLA_PIPE_SUB_EN only)
//   out_valid  out  result present on sum/cout/ovf
//   out_ready  in   consumer takes the result this cycle
//   sum        out  WIDTH-bit result
//   cout       out  carry out of bit WIDTH-1
//   ovf        out  two's-complement overflow (MSB carry-in ^ carry-out)
//   busy       out  some stage holds a valid operation
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. This holds on both the input side and the output side. The
// whole pipeline moves as one unit. When the output holds an unconsumed
// result, every stage holds its contents and in_ready is low.
// ---------------------------------------------------------------------------
module cla_pipe_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             cin,
`ifdef CLA_PIPE_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int SW = WIDTH / STAGES;  // slice width
    localparam int NG = SW / 4;          // lookahead groups per slice

    // Adds one slice.
    // Returns {carry_out, carry_into_slice_msb, sum[SW-1:0]}.
    function automatic logic [SW+1:0] cla_slice(
        input logic [SW-1:0] a,
        input logic [SW-1:0] b,
        input logic          ci
    );
        logic [SW-1:0] s;
        logic [3:0]    p;
        logic [3:0]    g;
        logic [3:0]    cc;
        logic          c;
        logic          cm;
        logic          co;
        s  = '0;
        c  = ci;
        cm = ci;
        for (int n = 0; n < NG; n++) begin
            p     = a[4*n +: 4] ^ b[4*n +: 4];
            g     = a[4*n +: 4] & b[4*n +: 4];
            cc[0] = c;
            cc[1] = g[0] | (p[0] & c);
            cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
            cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & c);
            co    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & c);
            s[4*n +: 4] = p ^ cc;
            cm = cc[3];
            c  = co;
        end
        return {c, cm, s};
    endfunction

    // Per-stage registers and their next-state values.
    logic             vld_q [STAGES];
    logic             vld_d [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic [WIDTH-1:0] sum_d [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic             c_q   [STAGES];
    logic             c_d   [STAGES];
    logic             ovf_q;
    logic             ovf_d;

    // Inputs seen by each stage's adder.
    logic             st_vld [STAGES];
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_b   [STAGES];
    logic             st_c   [STAGES];
    logic [WIDTH-1:0] st_sum [STAGES];

    logic             adv;
    logic [WIDTH-1:0] b0;
    logic             c0;
    logic [SW+1:0]    res;

    always_comb begin
        adv   = !vld_q[STAGES-1] || out_ready;
        b0    = op2;
        c0    = cin;
        ovf_d = 1'b0;
        res   = '0;
`ifdef CLA_PIPE_SUB_EN
        if (sub) begin
            b0 = ~op2;
            c0 = 1'b1;
        end
`endif
        // A bubble enters stage 0 as all-zero data, so empty slots never
        // carry stale sums down the pipe.
        st_vld[0] = in_valid;
        st_a[0]   = in_valid ? op1 : '0;
        st_b[0]   = in_valid ? b0  : '0;
        st_c[0]   = in_valid && c0;
        st_sum[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            st_vld[k] = vld_q[k-1];
            st_a[k]   = a_q[k-1];
            st_b[k]   = b_q[k-1];
            st_c[k]   = c_q[k-1];
            st_sum[k] = sum_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            res      = cla_slice(st_a[k][k*SW +: SW], st_b[k][k*SW +: SW], st_c[k]);
            vld_d[k] = st_vld[k];
            a_d[k]   = st_a[k];
            b_d[k]   = st_b[k];
            c_d[k]   = res[SW+1];
            sum_d[k] = st_sum[k];
            sum_d[k][k*SW +: SW] = res[SW-1:0];
            // The last slice holds the MSB, so overflow is decided here.
            if (k == STAGES - 1) begin
                ovf_d = res[SW] ^ res[SW+1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                c_q[k]   <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_d[k];
                sum_q[k] <= sum_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                c_q[k]   <= c_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            busy = busy | vld_q[k];
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder with WIDTH=64 and STAGES=4.
// The expected queue holds {cout, ovf, sum} for each accepted operation.
module tb_cla_pipe_adder;

    localparam int W = 64;
`ifdef CLA_PIPE_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         cin;
    logic         sub_s;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    cla_pipe_adder #(.WIDTH(W), .STAGES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .cin       (cin),
`ifdef CLA_PIPE_SUB_EN
        .sub       (sub_s),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    // ---------------- scoreboard ----------------
    logic [W+1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic. Overflow means the signed result
    // does not fit in W bits.
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic c, input logic s);
        logic [W:0]        u;
        logic signed [W:0] w;
        logic [W-1:0]      rs;
        logic              rc;
        if (s && SUB_EN) begin
            rs = a - b;
            rc = (a >= b);
            w  = $signed({a[W-1], a}) - $signed({b[W-1], b});
        end else begin
            u  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            rs = u[W-1:0];
            rc = u[W];
            w  = $signed({a[W-1], a}) + $signed({b[W-1], b}) + $signed({{W{1'b0}}, c});
        end
        return {rc, w[W] ^ w[W-1], rs};
    endfunction

    // Every consumed result is checked against the queue front.
    always @(negedge clk) begin
        if (mon_en && !rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL extra_result: got sum=%h, expected no result", sum);
            end else begin
                logic [W+1:0] e;
                e = exp_q.pop_front();
                chk("res_sum",  sum,  e[W-1:0]);
                chk("res_cout", {63'b0, cout}, {63'b0, e[W+1]});
                chk("res_ovf",  {63'b0, ovf},  {63'b0, e[W]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v;
        case ($urandom_range(0, 3))
            0:       v = '1;
            1:       v = {1'b0, {(W-1){1'b1}}};
            2:       v = {$urandom, 16'hffff, 16'h0000} ^ {32'h0, $urandom};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Presents one operation until it is accepted, then pushes exp.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s, input logic [W+1:0] exp);
        bit acc;
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) begin
            op1 = a; op2 = b; cin = c; sub_s = s; in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                exp_q.push_back(exp);
            end
            tick();
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, expected 1");
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int t = 0; t < cycles; t++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            op1 = {$urandom, $urandom}; op2 = {$urandom, $urandom};
            cin = 1'($urandom_range(0, 1)); sub_s = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic         s;
        logic [W-1:0] e_sum;
        logic         e_cout;
        logic         e_ovf;
    } vec_t;

    vec_t vecs[8];
    int   n_vec;

    initial begin : watchdog
        #400000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : main
        logic [W+1:0] e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic         s;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op1 = '0; op2 = '0; cin = 1'b0; sub_s = 1'b0;

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[2] = '{64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0, 1'b0};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[5] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
        n_vec = 6;
`ifdef CLA_PIPE_SUB_EN
        vecs[6] = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[7] = '{64'd7, 64'd5, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0};
        n_vec = 8;
`endif

        // Reset: two cycles with random inputs.
        tick();
        do_reset(2);
        mon_en = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("rst_out_valid", {63'b0, out_valid}, 64'h0);
        chk("rst_sum",       sum, 64'h0);
        chk("rst_cout",      {63'b0, cout}, 64'h0);
        chk("rst_ovf",       {63'b0, ovf},  64'h0);
        chk("rst_busy",      {63'b0, busy}, 64'h0);
        chk("rst_in_ready",  {63'b0, in_ready}, 64'h1);
        tick();
        out_ready = 1'b1;

        // Latency of the full carry chain: accepted at edge N, valid after N+3.
        op1 = vecs[0].a; op2 = vecs[0].b; cin = vecs[0].c; sub_s = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        chk("lat_in_ready", {63'b0, in_ready}, 64'h1);
        if (in_ready) exp_q.push_back({vecs[0].e_cout, vecs[0].e_ovf, vecs[0].e_sum});
        tick();
        in_valid = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            chk("lat_early_valid", {63'b0, out_valid}, 64'h0);
        end
        @(negedge clk);
        chk("lat_valid", {63'b0, out_valid}, 64'h1);
        tick();
        drain();

        // Table vectors, issued back-to-back.
        for (int i = 0; i < n_vec; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s,
                 {vecs[i].e_cout, vecs[i].e_ovf, vecs[i].e_sum});
        end
        drain();

        // Streaming: 16 back-to-back ops with out_ready held high.
        out_ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            if (j < 16) begin
                a = rand_op(); b = rand_op(); c = 1'($urandom_range(0, 1));
                op1 = a; op2 = b; cin = c; sub_s = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (j < 16) begin
                chk("stream_in_ready", {63'b0, in_ready}, 64'h1);
                if (in_ready) exp_q.push_back(ref_model(a, b, c, 1'b0));
            end
            chk("stream_out_valid", {63'b0, out_valid}, (j >= 4) ? 64'h1 : 64'h0);
            tick();
        end
        drain();

        // Stall: fill with out_ready low, hold for 5 cycles, then release.
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            a = rand_op(); b = rand_op(); c = 1'($urandom_range(0, 1));
            op1 = a; op2 = b; cin = c; sub_s = 1'b0; in_valid = 1'b1;
            @(negedge clk);
            chk("fill_in_ready", {63'b0, in_ready}, 64'h1);
            if (in_ready) exp_q.push_back(ref_model(a, b, c, 1'b0));
            tick();
        end
        for (int j = 0; j < 5; j++) begin
            op1 = {$urandom, $urandom}; op2 = {$urandom, $urandom};
            cin = 1'($urandom_range(0, 1)); in_valid = 1'b1;
            @(negedge clk);
            chk("stall_in_ready",  {63'b0, in_ready},  64'h0);
            chk("stall_out_valid", {63'b0, out_valid}, 64'h1);
            chk("stall_busy",      {63'b0, busy},      64'h1);
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                chk("stall_sum",  sum, e[W-1:0]);
                chk("stall_cout", {63'b0, cout}, {63'b0, e[W+1]});
                chk("stall_ovf",  {63'b0, ovf},  {63'b0, e[W]});
            end
            tick();
        end
        in_valid = 1'b0;
        chk("stall_pending", 64'(exp_q.size()), 64'd4);
        drain();
        repeat (3) begin
            @(negedge clk);
            chk("post_drain_valid", {63'b0, out_valid}, 64'h0);
            tick();
        end

        // Reset with three ops in flight: nothing may come out afterwards.
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            a = rand_op(); b = rand_op();
            send(a, b, 1'b0, 1'b0, ref_model(a, b, 1'b0, 1'b0));
        end
        do_reset(1);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("flush_out_valid", {63'b0, out_valid}, 64'h0);
            chk("flush_busy",      {63'b0, busy},      64'h0);
            tick();
        end

        // Random traffic with gaps and back-pressure.
        for (int j = 0; j < 120; j++) begin
            a = rand_op(); b = rand_op(); c = 1'($urandom_range(0, 1));
            s = SUB_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            op1 = a; op2 = b; cin = c; sub_s = s;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) exp_q.push_back(ref_model(a, b, c, s));
            tick();
        end
        in_valid = 1'b0;
        drain();
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
